// File: rtl/test_regs_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : test_regs_reg_file
// Description : Three 32-bit software registers (0x0, 0x4, 0x8) behind a
//               valid/ready register bus with combinational response.
//               Optional macro TEST_REGS_HW_UPDATE_EN adds a hardware update
//               path to REG2 (software write has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module test_regs_reg_file #(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          reg_valid_i,
    input  logic          reg_write_i,
    input  logic [AW-1:0] reg_addr_i,
    input  logic [31:0]   reg_wdata_i,
    input  logic [3:0]    reg_wstrb_i,
    output logic [31:0]   reg_rdata_o,
    output logic          reg_error_o,
    output logic          reg_ready_o,
    input  logic          devmode_i,
`ifdef TEST_REGS_HW_UPDATE_EN
    input  logic [31:0]   reg2_hw_d_i,
    input  logic          reg2_hw_de_i,
`endif
    output logic [31:0]   reg0_q_o,
    output logic [31:0]   reg1_q_o,
    output logic [31:0]   reg2_q_o,
    output logic          reg0_qe_o,
    output logic          reg1_qe_o,
    output logic          reg2_qe_o
);

    localparam int c_NUM_REGS = 3;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [AW-3:0]                       w_word;
    logic [c_NUM_REGS-1:0]               w_sel;
    logic [c_NUM_REGS-1:0]               w_sw_we;
    logic [c_NUM_REGS-1:0][31:0]         w_merged;
    logic [c_NUM_REGS-1:0][31:0]         w_reg_d;
    logic                                w_decode_err;
    logic                                w_wr_en;
    logic [c_NUM_REGS-1:0][31:0]         r_reg;
    logic [c_NUM_REGS-1:0]               r_qe;

    assign w_word       = reg_addr_i[AW-1:2];
    assign w_decode_err = (|reg_addr_i[1:0]) | ~(|w_sel);
    assign w_wr_en      = reg_valid_i & reg_write_i & ~w_decode_err;

    for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_reg
        assign w_sel[i]    = (w_word == (AW-2)'(i));
        assign w_sw_we[i]  = w_wr_en & w_sel[i];
        assign w_merged[i] = f_merge(r_reg[i], reg_wdata_i, reg_wstrb_i);
    end

    always_comb begin
        w_reg_d = r_reg;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            if (w_sw_we[i]) begin
                w_reg_d[i] = w_merged[i];
            end
        end
`ifdef TEST_REGS_HW_UPDATE_EN
        // Hardware load only lands when software is not writing REG2 this cycle
        if (reg2_hw_de_i && !w_sw_we[2]) begin
            w_reg_d[2] = reg2_hw_d_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_reg <= '0;
            r_qe  <= '0;
        end else begin
            r_reg <= w_reg_d;
            r_qe  <= w_sw_we;
        end
    end

    always_comb begin
        reg_rdata_o = '0;
        if (reg_valid_i && !reg_write_i && !w_decode_err) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_sel[i]) begin
                    reg_rdata_o = r_reg[i];
                end
            end
        end
    end

    assign reg_error_o = reg_valid_i & w_decode_err & devmode_i;
    assign reg_ready_o = 1'b1;

    assign reg0_q_o  = r_reg[0];
    assign reg1_q_o  = r_reg[1];
    assign reg2_q_o  = r_reg[2];
    assign reg0_qe_o = r_qe[0];
    assign reg1_qe_o = r_qe[1];
    assign reg2_qe_o = r_qe[2];

endmodule
`default_nettype wire

// File: tb/tb_test_regs_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_regs_reg_file
// Description : Table-driven bench for test_regs_reg_file with a scoreboard
//               queue holding expected post-edge register/qe state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_regs_reg_file;

    logic        clk;
    logic        rst;
    logic        valid, write, devmode;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        error, ready;
    logic [31:0] q0, q1, q2;
    logic        qe0, qe1, qe2;
`ifdef TEST_REGS_HW_UPDATE_EN
    logic [31:0] hw_d;
    logic        hw_de;
`endif

    test_regs_reg_file #(.AW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_valid_i (valid),
        .reg_write_i (write),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_wstrb_i (wstrb),
        .reg_rdata_o (rdata),
        .reg_error_o (error),
        .reg_ready_o (ready),
        .devmode_i   (devmode),
`ifdef TEST_REGS_HW_UPDATE_EN
        .reg2_hw_d_i (hw_d),
        .reg2_hw_de_i(hw_de),
`endif
        .reg0_q_o    (q0),
        .reg1_q_o    (q1),
        .reg2_q_o    (q2),
        .reg0_qe_o   (qe0),
        .reg1_qe_o   (qe1),
        .reg2_qe_o   (qe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        dev;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] q0, q1, q2;
        logic [2:0]  qe;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl[3];
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model of the register state after the coming edge
    task automatic model_step(input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s, input logic r);
        exp_t        e;
        logic [31:0] old[3];
        logic        hit;
        int          idx;
        e.qe = 3'b000;
        old  = mdl;
        hit  = (a[1:0] == 2'b00) && (a[31:2] < 3);
        idx  = int'(a[3:2]);
        if (r) begin
            mdl = '{32'h0, 32'h0, 32'h0};
        end else begin
`ifdef TEST_REGS_HW_UPDATE_EN
            if (hw_de) mdl[2] = hw_d;
`endif
            if (v && w && hit) begin
                for (int b = 0; b < 4; b++) begin
                    mdl[idx][8*b +: 8] = s[b] ? d[8*b +: 8] : old[idx][8*b +: 8];
                end
                e.qe[idx] = 1'b1;
            end
        end
        e.q0 = mdl[0];
        e.q1 = mdl[1];
        e.q2 = mdl[2];
        sb.push_back(e);
    endtask

    // Entered just after a rising edge; leaves just after the next one
    task automatic do_req(input string name, input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic dv, input logic r,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        valid = v; write = w; addr = a; wdata = d; wstrb = s; devmode = dv; rst = r;
        @(negedge clk);
        chk({name, " rdata"}, rdata, exp_rdata);
        chk({name, " error"}, {31'b0, error}, {31'b0, exp_err});
        chk({name, " ready"}, {31'b0, ready}, 32'h1);
        model_step(v, w, a, d, s, r);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard: got empty queue expected entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, " q0"}, q0, e.q0);
            chk({name, " q1"}, q1, e.q1);
            chk({name, " q2"}, q2, e.q2);
            chk({name, " qe"}, {29'b0, qe2, qe1, qe0}, {29'b0, e.qe});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl = '{32'h0, 32'h0, 32'h0};
        rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0; devmode = 1'b1;
`ifdef TEST_REGS_HW_UPDATE_EN
        hw_d = '0; hw_de = 1'b0;
`endif
        tbl[0]  = '{1'b1, 1'b1, 32'h0,   32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'h4,   32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8,   32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h4,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h4,   32'h12345678, 4'h5, 1'b1, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h4,   32'h0,        4'h0, 1'b1, 32'hDE34BE78, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h4,   32'hFFFFFFFF, 4'h0, 1'b1, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h4,   32'h0,        4'h0, 1'b1, 32'hDE34BE78, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'hC,   32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'h2,   32'h55555555, 4'hF, 1'b1, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'hC,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0};
        tbl[13] = '{1'b1, 1'b1, 32'h2,   32'h55555555, 4'hF, 1'b0, 32'h0,        1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h5,   32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        tbl[15] = '{1'b1, 1'b1, 32'h100, 32'h77777777, 4'hF, 1'b1, 32'h0,        1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset q0", q0, 32'h0);
        chk("reset q1", q1, 32'h0);
        chk("reset q2", q2, 32'h0);
        chk("reset qe", {29'b0, qe2, qe1, qe0}, 32'h0);
        chk("reset ready", {31'b0, ready}, 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].valid, tbl[i].write, tbl[i].addr,
                   tbl[i].wdata, tbl[i].strb, tbl[i].dev, 1'b0,
                   tbl[i].exp_rdata, tbl[i].exp_err);
        end

        // Reset with a concurrent write: the write must be discarded
        do_req("rst_w0", 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("rst_w1", 1'b1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("rst_w2", 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("rst_rd_pre", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
        do_req("rst_cyc", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0, 1'b0);
        do_req("rst_r0", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("rst_r1", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("rst_r2", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Register value is still old during the write cycle, new one after
        valid = 1'b1; write = 1'b1; addr = 32'h4; wdata = 32'h1; wstrb = 4'hF; devmode = 1'b1;
        @(negedge clk);
        chk("timing old q1", q1, 32'h0);
        model_step(1'b1, 1'b1, 32'h4, 32'h1, 4'hF, 1'b0);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        chk("timing new q1", q1, 32'h1);
        chk("timing qe1", {31'b0, qe1}, 32'h1);
        do_req("timing_rd", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1, 1'b0);
        chk("qe1 single pulse", {31'b0, qe1}, 32'h0);

        do_req("b2b_w0", 1'b1, 1'b1, 32'h4, 32'h000000AA, 4'h1, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("b2b_w1", 1'b1, 1'b1, 32'h4, 32'h0000BB00, 4'h2, 1'b1, 1'b0, 32'h0, 1'b0);
        do_req("b2b_rd", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000BBAA, 1'b0);

`ifdef TEST_REGS_HW_UPDATE_EN
        hw_de = 1'b1; hw_d = 32'hCAFEF00D;
        do_req("hw_ld", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        hw_de = 1'b0;
        do_req("hw_rd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
        hw_de = 1'b1; hw_d = 32'hCAFEF00D;
        do_req("hw_sw_w", 1'b1, 1'b1, 32'h8, 32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        hw_de = 1'b0;
        do_req("hw_sw_rd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 32'h11111111, 1'b0);
        hw_de = 1'b1; hw_d = 32'h12345678;
        do_req("hw_sw_p", 1'b1, 1'b1, 32'h8, 32'h000000EE, 4'h1, 1'b1, 1'b0, 32'h0, 1'b0);
        hw_de = 1'b0;
        do_req("hw_sw_prd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 32'h111111EE, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
